// File: rtl/sw_duty_conditioner.sv
// Switch conditioner for the PWM duty input: 2-FF synchroniser, whole-vector
// debounce, and duty updates applied only on PWM period boundaries (optionally slew-limited).
module sw_duty_conditioner #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int SLEW       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_raw,
    input  logic         period_tick,
    output logic [W-1:0] sw,
    output logic         sw_upd,
    output logic         settled
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [W-1:0]  s1_r;
    logic [W-1:0]  s2_r;
    logic [W-1:0]  cand_r;
    logic [W-1:0]  stable_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  sw_r;
    logic          sw_upd_r;

    logic [W-1:0]  cand_next_s;
    logic [W-1:0]  stable_next_s;
    logic [CW-1:0] cnt_next_s;
    logic [W-1:0]  sw_next_s;

    // Debounce next-state: any differing sample restarts the count; the count saturates at the limit.
    always_comb begin
        cand_next_s   = cand_r;
        cnt_next_s    = cnt_r;
        stable_next_s = stable_r;
        if (s2_r != cand_r) begin
            cand_next_s = s2_r;
            cnt_next_s  = {CW{1'b0}};
        end else if (cnt_r < CNT_MAX) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            stable_next_s = cand_r;
        end
    end

    // Duty next-state: only a period tick may move sw, always using the pre-edge stable value.
    always_comb begin
        sw_next_s = sw_r;
        if (period_tick) begin
            if (SLEW != 0) begin
                if (sw_r < stable_r) begin
                    sw_next_s = sw_r + W'(1);
                end else if (sw_r > stable_r) begin
                    sw_next_s = sw_r - W'(1);
                end else begin
                    sw_next_s = sw_r;
                end
            end else begin
                sw_next_s = stable_r;
            end
        end else begin
            sw_next_s = sw_r;
        end
    end

    // State registers: synchroniser, debounce, duty code and update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r     <= {W{1'b0}};
            s2_r     <= {W{1'b0}};
            cand_r   <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            stable_r <= {W{1'b0}};
            sw_r     <= {W{1'b0}};
            sw_upd_r <= 1'b0;
        end else begin
            s1_r     <= sw_raw;
            s2_r     <= s1_r;
            cand_r   <= cand_next_s;
            cnt_r    <= cnt_next_s;
            stable_r <= stable_next_s;
            sw_r     <= sw_next_s;
            sw_upd_r <= (sw_next_s != sw_r);
        end
    end

    assign sw      = sw_r;
    assign sw_upd  = sw_upd_r;
    assign settled = (sw_r == stable_r);

endmodule

// File: tb/tb_sw_duty_conditioner.sv
// Bench for sw_duty_conditioner: SLEW=1 and SLEW=0 instances share stimulus and are
// compared every cycle against a run-length/step-toward-target model of the switch path.
module tb_sw_duty_conditioner;

    localparam int W   = 4;
    localparam int DEB = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_raw = 4'd0;
    logic         period_tick = 1'b0;

    logic [W-1:0] sw_a, sw_b;
    logic         upd_a, upd_b, set_a, set_b;

    sw_duty_conditioner #(.W(W), .DEB_CYCLES(DEB), .SLEW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .period_tick(period_tick),
        .sw(sw_a), .sw_upd(upd_a), .settled(set_a));

    sw_duty_conditioner #(.W(W), .DEB_CYCLES(DEB), .SLEW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .period_tick(period_tick),
        .sw(sw_b), .sw_upd(upd_b), .settled(set_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;
    int upd_cnt_a = 0;
    int upd_cnt_b = 0;
    bit chk_en = 1'b0;
    bit track_en = 1'b0;
    int min_a = 99;
    int max_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: s2 is raw delayed by two samples; stable takes a value once the
    // last DEB+1 pre-edge samples of s2 agree (reset's cand=0 counts as one sample).
    logic [W-1:0] m_s1, m_s2, m_last, m_stable, m_sw_a, m_sw_b;
    logic         m_upd_a, m_upd_b;
    int           m_run;

    function automatic logic [W-1:0] step_to(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        if (cur < tgt) return cur + 4'd1;
        if (cur > tgt) return cur - 4'd1;
        return cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 4'd0; m_s2 <= 4'd0; m_last <= 4'd0; m_stable <= 4'd0;
            m_sw_a <= 4'd0; m_sw_b <= 4'd0; m_upd_a <= 1'b0; m_upd_b <= 1'b0;
            m_run <= 1;
        end else begin
            m_s1   <= sw_raw;
            m_s2   <= m_s1;
            m_last <= m_s2;
            m_run  <= (m_s2 == m_last) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
            if ((m_s2 == m_last) && (m_run + 1 >= DEB + 1)) m_stable <= m_s2;
            if (period_tick) begin
                m_sw_a  <= step_to(m_sw_a, m_stable);
                m_upd_a <= (m_sw_a != m_stable);
                m_sw_b  <= m_stable;
                m_upd_b <= (m_sw_b != m_stable);
            end else begin
                m_upd_a <= 1'b0;
                m_upd_b <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("sw_slew", sw_a, m_sw_a);
            chk("upd_slew", upd_a, m_upd_a);
            chk("settled_slew", set_a, m_sw_a == m_stable);
            chk("sw_jump", sw_b, m_sw_b);
            chk("upd_jump", upd_b, m_upd_b);
            chk("settled_jump", set_b, m_sw_b == m_stable);
            if (upd_a) upd_cnt_a++;
            if (upd_b) upd_cnt_b++;
            if (track_en) begin
                if (int'(sw_a) < min_a) min_a = int'(sw_a);
                if (int'(sw_a) > max_a) max_a = int'(sw_a);
            end
        end
    end

    // Advance n cycles; with per>0 a one-cycle tick is raised every per cycles.
    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            period_tick = (per > 0) && ((tcnt % per) == per - 1);
            tcnt++;
        end
    endtask

    initial begin
        int hold;
        bit found;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_sw", sw_a, 4'd0);
        chk("reset_settled", set_a, 1'b1);
        chk("reset_upd", upd_a, 1'b0);

        // Idle with periodic ticks: nothing may move.
        run(60, 20);
        chk("idle_sw", sw_a, 4'd0);
        chk("idle_upd_count", upd_cnt_a, 0);

        // Bouncing 0/3 every 4 cycles never survives debounce.
        for (int k = 0; k < 25; k++) begin
            sw_raw = (k % 2 == 1) ? 4'd3 : 4'd0;
            run(4, 20);
        end
        sw_raw = 4'd0;
        run(20, 20);
        chk("bounce_sw", sw_a, 4'd0);
        chk("bounce_upd_count", upd_cnt_a + upd_cnt_b, 0);

        // 0 -> 5 with slew: stable appears exactly 11 edges after the change.
        upd_cnt_a = 0; upd_cnt_b = 0;
        period_tick = 1'b0;
        sw_raw = 4'd5;
        run(10, 0);
        @(negedge clk);
        chk("deb_edge10_settled", set_a, 1'b1);
        run(1, 0);
        @(negedge clk);
        chk("deb_edge11_settled", set_a, 1'b0);
        run(120, 20);
        chk("ramp5_sw", sw_a, 4'd5);
        chk("ramp5_upd_count", upd_cnt_a, 5);
        chk("ramp5_settled", set_a, 1'b1);
        chk("jump5_upd_count", upd_cnt_b, 1);

        // Back to 0 using back-to-back ticks.
        sw_raw = 4'd0;
        run(12, 0);
        run(10, 1);
        run(3, 0);

        // SLEW=0: tick coincident with the stable update uses the old value.
        upd_cnt_b = 0;
        sw_raw = 4'd15;
        run(9, 0);
        @(posedge clk); #1 period_tick = 1'b1;
        @(posedge clk); #1 period_tick = 1'b0;
        @(negedge clk);
        chk("jump_same_tick_sw", sw_b, 4'd0);
        run(3, 0);
        @(posedge clk); #1 period_tick = 1'b1;
        @(posedge clk); #1 period_tick = 1'b0;
        run(2, 0);
        chk("jump15_sw", sw_b, 4'd15);
        chk("jump15_upd_count", upd_cnt_b, 1);

        // Return both to 0, then ramp toward 9 and redirect to 2 at sw=4.
        sw_raw = 4'd0;
        run(12, 0);
        run(20, 1);
        run(3, 0);
        sw_raw = 4'd9;
        run(12, 0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            run(1, 20);
            if (sw_a == 4'd4) found = 1'b1;
        end
        period_tick = 1'b0;
        if (!found) begin
            errors++;
            $display("FAIL ramp_reach4 actual=timeout required=sw 4");
        end
        sw_raw = 4'd2;
        min_a = 99; max_a = 0; track_en = 1'b1;
        run(12, 0);
        run(100, 20);
        track_en = 1'b0;
        chk("redirect_sw", sw_a, 4'd2);
        chk("redirect_min", min_a, 2);
        chk("redirect_max", max_a, 4);

        // Asynchronous reset in the middle of a ramp.
        sw_raw = 4'd12;
        run(12, 0);
        run(40, 20);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_sw", sw_a, 4'd0);
        chk("async_rst_upd", upd_a, 1'b0);
        chk("async_rst_sw_jump", sw_b, 4'd0);
        period_tick = 1'b0;
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        run(10, 1);
        chk("post_rst_hold", sw_a, 4'd0);
        run(10, 1);
        chk("post_rst_ramp", sw_a, 4'd9);
        chk("post_rst_jump", sw_b, 4'd12);

        // Randomised switch activity with random and back-to-back ticks.
        for (int seg = 0; seg < 150; seg++) begin
            sw_raw = W'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(9, 40);
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                period_tick = ($urandom_range(0, 6) == 0);
            end
        end
        period_tick = 1'b0;
        run(5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_duty_conditioner.md
Name: sw_duty_conditioner

Overview:
- Upstream stage of the 4-bit-duty PWM generator; produces its `sw` duty-select input.
- Synchronises and debounces the raw board switches.
- Applies duty changes only at PWM period boundaries, so no period is ever truncated or stretched mid-pulse.
- Optionally slew-limits changes to one code step per PWM period.

Parameters:
- W, 4, width of switch/duty code.
- DEB_CYCLES, 50000, consecutive identical synchronised samples required to accept a new switch value; must be >= 2.
- SLEW, 1, 1 = duty moves at most one code per period_tick; 0 = duty jumps to debounced value at next period_tick.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_raw  input  W  raw, asynchronous, bouncing switch inputs.
- period_tick  input  1  one-cycle pulse from the PWM stage when its counter wraps to 0 (synchronous to clk).
- sw  output  W  conditioned duty code driving the PWM stage.
- sw_upd  output  1  one-cycle pulse in the cycle after `sw` changes value.
- settled  output  1  high when sw equals the debounced switch value.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release):
  - sync stages, cand, stable, cnt, sw all 0.
  - sw_upd = 0; settled = 1.
- Synchroniser:
  - 2-FF chain sw_raw -> s1 -> s2, whole vector.
  - s2 lags sw_raw by 2 clocks.
- Debounce (whole vector, not per bit):
  - Registers cand[W], cnt[clog2(DEB_CYCLES)], stable[W].
  - If s2 != cand: cand <= s2, cnt <= 0.
  - Else if cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - Else (cnt == DEB_CYCLES-1): stable <= cand; cnt holds (saturates, no wrap).
  - A new value therefore reaches stable exactly DEB_CYCLES+1 cycles after s2 first shows it, provided s2 does not change in between.
  - Any differing sample restarts the count, including a partial glitch back to the old value.
  - If cand returns to the current stable value, stable is rewritten with the same value (no visible change).
- Duty update (sw register), evaluated only when period_tick = 1; decisions use the registered stable value from before the edge:
  - SLEW=1:
    - sw < stable: sw <= sw+1.
    - sw > stable: sw <= sw-1.
    - Equal: hold.
  - SLEW=0: sw <= stable.
  - period_tick = 0: sw holds regardless of stable.
  - Arithmetic is W-bit unsigned. Wrap is impossible: sw only moves toward stable, so 0 never decrements and 2^W-1 never increments.
- Simultaneous events: period_tick in the same cycle stable changes uses the old stable; the new value takes effect at the next tick.
- sw_upd: registered; asserts for one cycle when sw changed on the previous edge; never asserts when a tick leaves sw unchanged.
- settled: combinational, (sw == stable).
- No back-pressure or handshake. Back-to-back ticks (period_tick high on consecutive cycles) are legal; each one steps sw.
- Reset mid-operation: all state cleared immediately, including a ramp in progress; after release, debounce restarts from cand = 0.

Test Plan (DEB_CYCLES=8 for simulation):
- Reset, sw_raw=0, ticks every 20 cycles -> sw=0, settled=1, sw_upd never asserts.
- sw_raw 0->4'd5 held steady, SLEW=1 -> stable=5 at 2+9=11 cycles after change; sw steps 1,2,3,4,5 on the next five ticks; sw_upd pulses 5 times; settled rises with the last step.
- sw_raw toggles 0/3 every 4 cycles for 100 cycles then returns to 0 -> stable stays 0, sw stays 0, no sw_upd.
- SLEW=0, stable 0->4'd15, tick lands in the same cycle stable updates -> sw still 0 after that tick; sw=15 after the next tick; exactly one sw_upd.
- Ramp 0->9 in progress at sw=4, switches changed to 2 -> sw goes 3, then 2, then holds; no overshoot, never below 2.
- rst_n pulsed low mid-ramp, asynchronous to clk -> sw=0 and sw_upd=0 immediately; debounce restarts, and sw ramps again only after DEB_CYCLES+1 stable cycles plus ticks.
